// File: rtl/parity_gen_if.sv
// parity_gen_if: producer-side and FIFO-push-side handshake bundle for parity_gen.
//   slave modport  : the encoder (parity_gen) side
//   master modport : producer + FIFO push side (testbench / surrounding logic)
// Signals:
//   data_i       raw payload word
//   valid_i      producer word valid
//   grant_o      encoder ready to accept (registered)
//   push_data_o  encoded word toward FIFO
//   push_valid_o encoded word valid toward FIFO
//   push_grant_i FIFO accepts
//   word_cnt_o   words delivered to FIFO, wrapping
`timescale 1ns/1ps

interface parity_gen_if #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
);
    localparam int DATA_WIDTH = WIDTH + 1;

    logic [WIDTH-1:0]      data_i;
    logic                  valid_i;
    logic                  grant_o;
    logic [DATA_WIDTH-1:0] push_data_o;
    logic                  push_valid_o;
    logic                  push_grant_i;
    logic [CNT_WIDTH-1:0]  word_cnt_o;

    modport slave (
        input  data_i, valid_i, push_grant_i,
        output grant_o, push_data_o, push_valid_o, word_cnt_o
    );

    modport master (
        output data_i, valid_i, push_grant_i,
        input  grant_o, push_data_o, push_valid_o, word_cnt_o
    );
endinterface

// File: rtl/parity_gen.sv
// parity_gen: appends one parity bit (MSB or LSB) to each WIDTH-bit payload and
// pushes the encoded word into a FIFO through a 2-entry skid buffer, so the
// producer sees a registered grant while full throughput is kept.
// Ports:
//   clk           clock, all state on rising edge
//   rst_n         asynchronous active-low reset
//   err_inject_i  (only with PARITY_ERR_INJECT_EN) invert parity of the word accepted this cycle
//   bus           parity_gen_if.slave: data_i/valid_i/grant_o, push_data_o/push_valid_o/push_grant_i, word_cnt_o
// Optional build macro: PARITY_ERR_INJECT_EN adds err_inject_i.
//
// state | meaning
// EMPTY | no word buffered, push_valid_o low
// ONE   | head register holds the only word
// FULL  | head holds oldest word, skid holds the next; grant_o low
`timescale 1ns/1ps

module parity_gen #(
    parameter int WIDTH       = 8,
    parameter     PARITY_BIT  = "MSB",
    parameter     PARITY_TYPE = "EVEN",
    parameter int CNT_WIDTH   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef PARITY_ERR_INJECT_EN
    input  logic        err_inject_i,
`endif
    parity_gen_if.slave bus
);
    localparam int DATA_WIDTH = WIDTH + 1;
    localparam bit PAR_MSB    = (PARITY_BIT == "MSB");
    localparam bit PAR_EVEN   = (PARITY_TYPE == "EVEN");

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t                state_q, state_d;
    logic                  grant_q;
    logic [DATA_WIDTH-1:0] head_q, skid_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  in_xfer, out_xfer;
    logic                  par_bit;
    logic [DATA_WIDTH-1:0] enc_word;
    logic                  load_head_new, load_skid_new, move_skid;

    assign in_xfer  = bus.valid_i && grant_q;
    assign out_xfer = (state_q != EMPTY) && bus.push_grant_i;

    always_comb begin
        par_bit = ^bus.data_i;
        if (!PAR_EVEN) par_bit = ~par_bit;
`ifdef PARITY_ERR_INJECT_EN
        par_bit = par_bit ^ err_inject_i;
`endif
        enc_word = PAR_MSB ? {par_bit, bus.data_i} : {bus.data_i, par_bit};
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            grant_q <= 1'b0;
        end else begin
            state_q <= state_d;
            // grant follows the next state, so push_grant_i only reaches grant_o through a flop
            grant_q <= (state_d != FULL);
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (in_xfer) state_d = ONE;
            ONE: begin
                if (in_xfer && !out_xfer)      state_d = FULL;
                else if (!in_xfer && out_xfer) state_d = EMPTY;
            end
            FULL:    if (out_xfer) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    // datapath controls
    always_comb begin
        load_head_new = 1'b0;
        load_skid_new = 1'b0;
        move_skid     = 1'b0;
        unique case (state_q)
            EMPTY: load_head_new = in_xfer;
            ONE: begin
                load_head_new = in_xfer && out_xfer;
                load_skid_new = in_xfer && !out_xfer;
            end
            FULL:    move_skid = out_xfer;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            skid_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (load_head_new)  head_q <= enc_word;
            else if (move_skid) head_q <= skid_q;
            if (load_skid_new)  skid_q <= enc_word;
            if (out_xfer)       cnt_q  <= cnt_q + 1'b1;
        end
    end

    assign bus.grant_o      = grant_q;
    assign bus.push_valid_o = (state_q != EMPTY);
    assign bus.push_data_o  = head_q;
    assign bus.word_cnt_o   = cnt_q;
endmodule

// File: tb/tb_parity_gen.sv
`timescale 1ns/1ps

module tb_parity_gen;
    localparam int WIDTH     = 8;
    localparam int CNT_WIDTH = 4;
    localparam int DW        = WIDTH + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

`ifdef PARITY_ERR_INJECT_EN
    logic err_inject_i = 1'b0;
`endif

    parity_gen_if #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus_em ();
    parity_gen_if #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus_ol ();

    assign bus_ol.data_i       = bus_em.data_i;
    assign bus_ol.valid_i      = bus_em.valid_i;
    assign bus_ol.push_grant_i = bus_em.push_grant_i;

    parity_gen #(.WIDTH(WIDTH), .PARITY_BIT("MSB"), .PARITY_TYPE("EVEN"), .CNT_WIDTH(CNT_WIDTH)) u_em (
        .clk(clk),
        .rst_n(rst_n),
`ifdef PARITY_ERR_INJECT_EN
        .err_inject_i(err_inject_i),
`endif
        .bus(bus_em.slave)
    );

    parity_gen #(.WIDTH(WIDTH), .PARITY_BIT("LSB"), .PARITY_TYPE("ODD"), .CNT_WIDTH(CNT_WIDTH)) u_ol (
        .clk(clk),
        .rst_n(rst_n),
`ifdef PARITY_ERR_INJECT_EN
        .err_inject_i(err_inject_i),
`endif
        .bus(bus_ol.slave)
    );

    typedef struct packed {
        logic [DW-1:0] em;
        logic [DW-1:0] ol;
    } exp_t;

    exp_t                 sb[$];
    int                   n_vec = 0;
    int                   n_err = 0;
    bit                   mon_en = 1'b0;
    int                   occ = 0;
    bit                   exp_grant = 1'b0;
    logic [CNT_WIDTH-1:0] exp_cnt = '0;
    bit                   in_x, out_x;
    exp_t                 e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoding: parity chosen so the total ones count comes out even/odd.
    function automatic logic [DW-1:0] enc(input logic [WIDTH-1:0] d, input bit even, input bit msb, input bit inj);
        bit p;
        p = ($countones(d) % 2) == 1;
        if (!even) p = !p;
        if (inj)   p = !p;
        return msb ? {p, d} : {d, p};
    endfunction

    task automatic drive(input logic [WIDTH-1:0] d, input bit v, input bit g, input bit inj, output bit acc);
        bit inj_eff;
        @(posedge clk);
        #1;
        bus_em.data_i       = d;
        bus_em.valid_i      = v;
        bus_em.push_grant_i = g;
`ifdef PARITY_ERR_INJECT_EN
        err_inject_i = inj;
        inj_eff = inj;
`else
        inj_eff = 1'b0;
        if (inj) inj_eff = 1'b0;
`endif
        acc = v && bus_em.grant_o;
        if (acc) sb.push_back('{em: enc(d, 1'b1, 1'b1, inj_eff), ol: enc(d, 1'b0, 1'b0, inj_eff)});
    endtask

    // Monitor: at each falling edge, check handshake state against the occupancy
    // model and pop/compare the word the coming rising edge will transfer.
    always @(negedge clk) begin
        if (mon_en) begin
            check("grant_o", 32'(bus_em.grant_o), 32'(exp_grant));
            check("grant_o_odd", 32'(bus_ol.grant_o), 32'(exp_grant));
            check("push_valid_o", 32'(bus_em.push_valid_o), 32'(occ > 0));
            check("push_valid_o_odd", 32'(bus_ol.push_valid_o), 32'(occ > 0));
            check("word_cnt_o", 32'(bus_em.word_cnt_o), 32'(exp_cnt));
            in_x  = bus_em.valid_i && bus_em.grant_o;
            out_x = bus_em.push_valid_o && bus_em.push_grant_i;
            if (out_x) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_push: got 0x%0h, expected no word at %0t", bus_em.push_data_o, $time);
                end else begin
                    e = sb.pop_front();
                    check("push_data_o", 32'(bus_em.push_data_o), 32'(e.em));
                    check("push_data_o_odd", 32'(bus_ol.push_data_o), 32'(e.ol));
                end
                exp_cnt = exp_cnt + 1'b1;
            end
            occ = occ + int'(in_x) - int'(out_x);
            exp_grant = (occ < 2);
        end
    end

    task automatic release_reset();
        @(negedge clk);
        rst_n     = 1'b1;
        occ       = 0;
        exp_cnt   = '0;
        exp_grant = 1'b1;
        sb.delete();
    endtask

    task automatic drain();
        bit acc;
        for (int i = 0; i < 40 && sb.size() != 0; i++) drive('0, 1'b0, 1'b1, 1'b0, acc);
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d words pending, expected 0", sb.size());
        end
        repeat (2) drive('0, 1'b0, 1'b1, 1'b0, acc);
    endtask

    initial begin
        bit acc;
        logic [WIDTH-1:0] stream [3];
        stream[0] = 8'h03; stream[1] = 8'h00; stream[2] = 8'hFF;

        bus_em.data_i       = '0;
        bus_em.valid_i      = 1'b0;
        bus_em.push_grant_i = 1'b0;

        #12;
        check("rst_grant_o", 32'(bus_em.grant_o), 32'd0);
        check("rst_push_valid_o", 32'(bus_em.push_valid_o), 32'd0);
        check("rst_push_data_o", 32'(bus_em.push_data_o), 32'd0);
        check("rst_word_cnt_o", 32'(bus_em.word_cnt_o), 32'd0);

        release_reset();
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // single word: 0x07 -> 0x107 (even/msb), 0x00E (odd/lsb)
        drive(8'h07, 1'b1, 1'b1, 1'b0, acc);
        drive(8'h00, 1'b0, 1'b1, 1'b0, acc);
        @(negedge clk);
        #1;
        check("first_word_em", 32'(bus_em.push_data_o), 32'h107);
        check("first_word_ol", 32'(bus_ol.push_data_o), 32'h00E);
        drain();
        check("cnt_after_first", 32'(bus_em.word_cnt_o), 32'd1);

        // back-to-back stream
        for (int i = 0; i < 3; i++) drive(stream[i], 1'b1, 1'b1, 1'b0, acc);
        drain();

        // backpressure: two words fill the buffer, third held off until space frees
        drive(8'h11, 1'b1, 1'b0, 1'b0, acc);
        drive(8'h22, 1'b1, 1'b0, 1'b0, acc);
        drive(8'h33, 1'b1, 1'b0, 1'b0, acc);
        drive(8'h33, 1'b1, 1'b0, 1'b0, acc);
        acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) drive(8'h33, 1'b1, 1'b1, 1'b0, acc);
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL held_word_accept: got no accept, expected 0x33 accepted");
        end
        drain();

`ifdef PARITY_ERR_INJECT_EN
        drive(8'h07, 1'b1, 1'b1, 1'b1, acc);
        drive(8'h07, 1'b1, 1'b1, 1'b0, acc);
        drain();
`endif

        // randomized traffic, with phases of heavy backpressure
        for (int i = 0; i < 600; i++) begin
            drive(WIDTH'($urandom), $urandom_range(0, 3) != 0,
                  (i % 100 < 50) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
                  $urandom_range(0, 7) == 0, acc);
        end
        drain();

        // reset while FULL
        drive(8'hAA, 1'b1, 1'b0, 1'b0, acc);
        drive(8'h55, 1'b1, 1'b0, 1'b0, acc);
        drive(8'h00, 1'b0, 1'b0, 1'b0, acc);
        mon_en = 1'b0;
        check("full_push_valid_o", 32'(bus_em.push_valid_o), 32'd1);
        check("full_grant_o", 32'(bus_em.grant_o), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_push_valid_o", 32'(bus_em.push_valid_o), 32'd0);
        check("midrst_word_cnt_o", 32'(bus_em.word_cnt_o), 32'd0);
        check("midrst_grant_o", 32'(bus_em.grant_o), 32'd0);
        check("midrst_push_data_o", 32'(bus_em.push_data_o), 32'd0);
        check("midrst_push_valid_o_odd", 32'(bus_ol.push_valid_o), 32'd0);
        bus_em.push_grant_i = 1'b1;
        repeat (2) @(posedge clk);
        release_reset();
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        drive(8'h5A, 1'b1, 1'b1, 1'b0, acc);
        drive(8'hC3, 1'b1, 1'b1, 1'b0, acc);
        drain();
        check("post_rst_cnt", 32'(bus_em.word_cnt_o), 32'd2);

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end
endmodule
